// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler granting a shared loadable counter to two requesters
module counter_sched #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] start0,
    input  logic [W-1:0] start1,
    input  logic [W-1:0] stop0,
    input  logic [W-1:0] stop1,
    input  logic [W-1:0] cnt_c,
    output logic         cnt_load,
    output logic         cnt_en,
    output logic [W-1:0] cnt_b,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t       state;
    logic         owner;
    logic         rr;
    logic [W-1:0] st_q;
    logic [W-1:0] sp_q;
    logic         win;
    logic         own_req;

    // on a tie the requester not served last wins; a lone request always wins
    assign win     = (req0 & req1) ? ~rr : req1;
    assign own_req = owner ? req1 : req0;

    // run sequencing: grant, load, count to stop, report; owner dropping req aborts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
            rr    <= 1'b1;
            st_q  <= '0;
            sp_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    owner <= win;
                    st_q  <= win ? start1 : start0;
                    sp_q  <= win ? stop1 : stop0;
                    state <= LOAD;
                end
                LOAD: if (!own_req) begin
                    rr    <= owner;
                    state <= IDLE;
                end else begin
                    state <= RUN;
                end
                RUN: if (!own_req) begin
                    rr    <= owner;
                    state <= IDLE;
                end else if (cnt_c == sp_q) begin
                    state <= DONE;
                end
                DONE: begin
                    rr    <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // outputs decode from state so reset clears them without waiting for clk
    always_comb begin
        busy     = (state != IDLE);
        gnt0     = busy & ~owner;
        gnt1     = busy & owner;
        done0    = (state == DONE) & ~owner;
        done1    = (state == DONE) & owner;
        cnt_load = (state == LOAD);
        cnt_b    = cnt_load ? st_q : '0;
        cnt_en   = (state == RUN) && (cnt_c != sp_q);
    end
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed checks of counter_sched with a modelled external counter
module tb_counter_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] start0 = '0, start1 = '0, stop0 = '0, stop1 = '0;
    logic [11:0] cnt_c;
    logic        cnt_load, cnt_en, gnt0, gnt1, done0, done1, busy;
    logic [11:0] cnt_b;
    logic [6:0]  flags;
    int          checks = 0;
    int          errors = 0;

    counter_sched #(.W(12)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .start0(start0), .start1(start1), .stop0(stop0), .stop1(stop1),
        .cnt_c(cnt_c), .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_b(cnt_b),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy)
    );

    always #5 clk = ~clk;

    assign flags = {busy, gnt0, gnt1, done0, done1, cnt_load, cnt_en};

    // the shared loadable counter the scheduler drives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_c <= '0;
        else if (cnt_load) cnt_c <= cnt_b;
        else if (cnt_en) cnt_c <= cnt_c + 12'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] f, input logic [11:0] b);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_flags"}, {25'd0, flags}, {25'd0, f});
        chk({tag, "_cnt_b"}, {20'd0, cnt_b}, {20'd0, b});
    endtask

    // flags = {busy, gnt0, gnt1, done0, done1, cnt_load, cnt_en}
    initial begin
        #1;
        chk("rst_flags", {25'd0, flags}, 32'd0);
        chk("rst_cnt_b", {20'd0, cnt_b}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step("idle0", 7'b0000000, 12'h000);
        // basic run 5 -> 8
        start0 = 12'h005; stop0 = 12'h008; req0 = 1'b1;
        step("b_load", 7'b1100010, 12'h005);
        step("b_run5", 7'b1100001, 12'h000); chk("b_c5", {20'd0, cnt_c}, 32'h005);
        step("b_run6", 7'b1100001, 12'h000); chk("b_c6", {20'd0, cnt_c}, 32'h006);
        step("b_run7", 7'b1100001, 12'h000); chk("b_c7", {20'd0, cnt_c}, 32'h007);
        step("b_cmp",  7'b1100000, 12'h000); chk("b_c8", {20'd0, cnt_c}, 32'h008);
        step("b_done", 7'b1101000, 12'h000);
        req0 = 1'b0;
        step("b_idle", 7'b0000000, 12'h000);
        // wrap-around FFE -> 001
        start1 = 12'hFFE; stop1 = 12'h001; req1 = 1'b1;
        step("w_load", 7'b1010010, 12'hFFE);
        step("w_run0", 7'b1010001, 12'h000); chk("w_cFFE", {20'd0, cnt_c}, 32'hFFE);
        step("w_run1", 7'b1010001, 12'h000); chk("w_cFFF", {20'd0, cnt_c}, 32'hFFF);
        step("w_run2", 7'b1010001, 12'h000); chk("w_c000", {20'd0, cnt_c}, 32'h000);
        step("w_cmp",  7'b1010000, 12'h000); chk("w_c001", {20'd0, cnt_c}, 32'h001);
        step("w_done", 7'b1010100, 12'h000);
        req1 = 1'b0;
        step("w_idle", 7'b0000000, 12'h000);
        // zero-length run
        start0 = 12'h123; stop0 = 12'h123; req0 = 1'b1;
        step("z_load", 7'b1100010, 12'h123);
        step("z_run",  7'b1100000, 12'h000); chk("z_c", {20'd0, cnt_c}, 32'h123);
        step("z_done", 7'b1101000, 12'h000);
        req0 = 1'b0;
        step("z_idle", 7'b0000000, 12'h000);
        // tie after reset: 0, 1, 0 alternating with IDLE gaps
        reset = 1'b0;
        #1;
        chk("t_rst", {25'd0, flags}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        start0 = 12'h010; stop0 = 12'h011; start1 = 12'h020; stop1 = 12'h020;
        req0 = 1'b1; req1 = 1'b1;
        step("t_load0", 7'b1100010, 12'h010);
        step("t_run0a", 7'b1100001, 12'h000);
        step("t_run0b", 7'b1100000, 12'h000);
        step("t_done0", 7'b1101000, 12'h000);
        step("t_gap0",  7'b0000000, 12'h000);
        step("t_load1", 7'b1010010, 12'h020);
        step("t_run1",  7'b1010000, 12'h000);
        step("t_done1", 7'b1010100, 12'h000);
        step("t_gap1",  7'b0000000, 12'h000);
        step("t_load2", 7'b1100010, 12'h010);
        req0 = 1'b0; req1 = 1'b0;
        step("t_abort", 7'b0000000, 12'h000);
        // abort of requester 1 after two RUN cycles, pending req0 follows
        start1 = 12'h000; stop1 = 12'h00A; req1 = 1'b1;
        step("a_load", 7'b1010010, 12'h000);
        step("a_run0", 7'b1010001, 12'h000); chk("a_c0", {20'd0, cnt_c}, 32'h000);
        step("a_run1", 7'b1010001, 12'h000); chk("a_c1", {20'd0, cnt_c}, 32'h001);
        req1 = 1'b0; req0 = 1'b1; start0 = 12'h030; stop0 = 12'h030;
        step("a_idle", 7'b0000000, 12'h000); chk("a_c2", {20'd0, cnt_c}, 32'h002);
        step("a_load0", 7'b1100010, 12'h030);
        start0 = 12'h077; stop0 = 12'h077;
        step("a_run", 7'b1100000, 12'h000); chk("a_c30", {20'd0, cnt_c}, 32'h030);
        step("a_done", 7'b1101000, 12'h000);
        req0 = 1'b0;
        step("a_end", 7'b0000000, 12'h000);
        // reset mid-run
        start0 = 12'h000; stop0 = 12'h050; req0 = 1'b1;
        step("r_load", 7'b1100010, 12'h000);
        step("r_run0", 7'b1100001, 12'h000);
        step("r_run1", 7'b1100001, 12'h000);
        #2 reset = 1'b0;
        #1;
        chk("r_async_flags", {25'd0, flags}, 32'd0);
        chk("r_async_cnt_b", {20'd0, cnt_b}, 32'd0);
        @(posedge clk);
        #1;
        chk("r_held", {25'd0, flags}, 32'd0);
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0;
        step("r_idle", 7'b0000000, 12'h000);
        req0 = 1'b1;
        step("r_load2", 7'b1100010, 12'h000);
        req0 = 1'b0;
        step("r_end", 7'b0000000, 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The block SHALL have parameter W, default 12, giving the width of the shared counter datapath.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0, req1  input  1 each  count-run requests from requester 0 and requester 1, level-held.
REQ-005 The block SHALL have ports start0, start1  input  W each  the value loaded into the counter for each requester's run.
REQ-006 The block SHALL have ports stop0, stop1  input  W each  the terminal count value for each requester's run.
REQ-007 The block SHALL have port cnt_c  input  W  the current value of the shared loadable counter.
REQ-008 The block SHALL have ports cnt_load  output  1, cnt_en  output  1, cnt_b  output  W, which drive the counter's load, enable and load-data inputs.
REQ-009 The block SHALL have ports gnt0, gnt1  output  1 each  the owner of the counter; at most one is high.
REQ-010 The block SHALL have ports done0, done1  output  1 each  one-cycle run-complete pulses.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN and DONE, and SHALL hold the grant owner, latched start (st_q), latched stop (sp_q) and a round-robin pointer rr (the last served requester).
REQ-013 IDLE SHALL behave as follows: if any req is high, grant the requester per REQ-014, latch its start/stop into st_q/sp_q, and move to LOAD; otherwise stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: if a single req is high, that requester wins; if both are high, the requester other than rr wins.
REQ-015 LOAD SHALL last one cycle with cnt_load=1, cnt_b=st_q and cnt_en=0, then move to RUN.
REQ-016 RUN SHALL drive cnt_en=(cnt_c!=sp_q) combinationally, with cnt_load=0.
REQ-017 When cnt_c==sp_q in RUN, the FSM SHALL move to DONE.
REQ-018 DONE SHALL last one cycle and SHALL pulse done of the owner, set rr to the owner, and move to IDLE.
REQ-019 gnt of the owner SHALL be high in LOAD, RUN and DONE, and low in IDLE.
REQ-020 In all states other than LOAD, cnt_load SHALL be 0 and cnt_b SHALL be 0.
REQ-021 In all states other than RUN, cnt_en SHALL be 0.
REQ-022 Counting SHALL wrap modulo 2^W, so a run with stop<start wraps through 0; the RUN length SHALL be d=(sp_q-st_q) mod 2^W enable cycles plus one compare cycle.
REQ-023 When start==stop, RUN SHALL last exactly one cycle with cnt_en=0.
REQ-024 The latency from grant to done pulse SHALL be 1 (LOAD) + d+1 (RUN) + 1 (DONE) cycles.
REQ-025 The latency from req sampled in IDLE to gnt high SHALL be one cycle.
REQ-026 Abort: if the owner's req falls while in LOAD or RUN, the FSM SHALL go to IDLE on the next edge with no done pulse, set rr to the owner, and drive cnt_en=0 from that edge onward.
REQ-027 Changes to start/stop inputs after the grant SHALL have no effect on the run in progress.
REQ-028 The next grant SHALL occur no earlier than the cycle after DONE, which gives a one-cycle IDLE gap between runs.
REQ-029 A non-owner's req SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-030 While reset=0, the FSM SHALL be asynchronously forced to IDLE with rr=1, so requester 0 wins the first tie.
REQ-031 While reset=0, st_q and sp_q SHALL be 0 and all outputs (gnt0/1, done0/1, cnt_load, cnt_en, cnt_b, busy) SHALL be 0.
REQ-032 A reset asserted mid-run SHALL abort immediately with no done pulse.
REQ-033 The first grant after reset release SHALL come no earlier than the first rising edge with reset=1.

Verification
REQ-034 The bench SHALL cover a basic run: req0=1, start0=0x005, stop0=0x008 -> gnt0 next cycle; one LOAD cycle with cnt_b=0x005; cnt_en high for 3 cycles; done0 pulses after cnt_c reaches 0x008; run spans 6 cycles from gnt0.
REQ-035 The bench SHALL cover wrap-around: start1=0xFFE, stop1=0x001 -> cnt_c sequence 0xFFE, 0xFFF, 0x000, 0x001; 3 enable cycles, then done1.
REQ-036 The bench SHALL cover a zero-length run: start0=stop0=0x123 -> LOAD, one RUN cycle with cnt_en=0, done0; total 3 cycles from gnt0.
REQ-037 The bench SHALL cover a tie and fairness case: req0=req1=1 held after reset -> gnt0 first, then gnt1, then gnt0, alternating, with one IDLE cycle between runs.
REQ-038 The bench SHALL cover abort: req1 drops after 2 RUN cycles of a 10-count run -> IDLE next edge, cnt_en=0, no done1, and a pending req0 is granted on the following cycle.
REQ-039 The bench SHALL cover reset mid-run: reset=0 asynchronously during RUN -> all outputs go 0 without waiting for clk, no done pulse, and the FSM is in IDLE after release.
